bram_tdp_mixed_width: RTL and testbench



---
 rtl/bram_pkg.sv | 31 +++
 rtl/bram_port_rdpath.sv | 75 +++++++
 rtl/bram_tdp_mixed_width.sv | 143 ++++++++++++++
 tb/tb_bram_tdp_mixed_width.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared types and elaboration helpers for the mixed-width true-dual-port RAM.
package bram_pkg;

    // Behaviour of a port's read register when that same port writes.
    typedef enum logic [1:0] {
        READ_FIRST  = 2'd0,
        WRITE_FIRST = 2'd1,
        NO_CHANGE   = 2'd2
    } rd_mode_e;

    // Port widths supported by the aspect-ratio logic.
    function automatic bit is_legal_width(input int w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16) || (w == 32);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    // Word-address width for a port of width w over mem_bits of storage.
    function automatic int addr_width(input int mem_bits, input int w);
        int words = mem_bits / w;
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    // One enable per byte; narrow ports get a single whole-word enable.
    function automatic int be_width(input int w);
        return (w >= 8) ? (w / 8) : 1;
    endfunction

endpackage

// File: rtl/bram_port_rdpath.sv
// Per-port read path: read-during-write selection, stage-1 read register and
// an optional output register. Both registers clear asynchronously.
module bram_port_rdpath
    import bram_pkg::*;
#(
    parameter int W       = 32,
    parameter int RD_MODE = 0,
    parameter int OUT_REG = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         we,
    input  logic [W-1:0] old_data,
    input  logic [W-1:0] wdata,
    input  logic [W-1:0] wmask,
    output logic [W-1:0] rdata
);

    localparam rd_mode_e MODE = rd_mode_e'(RD_MODE);

    logic [W-1:0] stage1_reg;
    logic [W-1:0] stage1_next;
    logic [W-1:0] merged;

    // Word as it will look after this port's write: enabled bytes new, rest old.
    always_comb begin
        merged = (wdata & wmask) | (old_data & ~wmask);
    end

    // Select what the read register captures; disabled port holds its value.
    always_comb begin
        stage1_next = stage1_reg;
        if (en) begin
            if (!we) begin
                stage1_next = old_data;
            end else begin
                case (MODE)
                    READ_FIRST:  stage1_next = old_data;
                    WRITE_FIRST: stage1_next = merged;
                    default:     stage1_next = stage1_reg;
                endcase
            end
        end
    end

    // Stage-1 read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_reg <= '0;
        end else begin
            stage1_reg <= stage1_next;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [W-1:0] out_reg;

            // Output stage loads every cycle regardless of enable.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_reg <= '0;
                end else begin
                    out_reg <= stage1_reg;
                end
            end

            assign rdata = out_reg;
        end else begin : g_no_out_reg
            assign rdata = stage1_reg;
        end
    endgenerate

endmodule

// File: rtl/bram_tdp_mixed_width.sv
// True-dual-port RAM with an independent data width on each port. Both ports
// view one flat bit array; word n of width W is bits [n*W +: W].
module bram_tdp_mixed_width
    import bram_pkg::*;
#(
    parameter int                  WIDTH_A   = 32,
    parameter int                  WIDTH_B   = 32,
    parameter int                  MEM_BITS  = 32768,
    parameter int                  RD_MODE_A = 0,
    parameter int                  RD_MODE_B = 0,
    parameter int                  OUT_REG_A = 0,
    parameter int                  OUT_REG_B = 0,
    parameter logic [MEM_BITS-1:0] INIT      = '0
) (
    input  logic                                    CLK_i,
    input  logic                                    RESET_ni,
    input  logic                                    EN_A_i,
    input  logic                                    WE_A_i,
    input  logic [be_width(WIDTH_A)-1:0]            BE_A_i,
    input  logic [addr_width(MEM_BITS, WIDTH_A)-1:0] ADDR_A_i,
    input  logic [WIDTH_A-1:0]                      WDATA_A_i,
    output logic [WIDTH_A-1:0]                      RDATA_A_o,
    input  logic                                    EN_B_i,
    input  logic                                    WE_B_i,
    input  logic [be_width(WIDTH_B)-1:0]            BE_B_i,
    input  logic [addr_width(MEM_BITS, WIDTH_B)-1:0] ADDR_B_i,
    input  logic [WIDTH_B-1:0]                      WDATA_B_i,
    output logic [WIDTH_B-1:0]                      RDATA_B_o
);

    localparam int BW   = $clog2(MEM_BITS);
    localparam int LW_A = $clog2(WIDTH_A);
    localparam int LW_B = $clog2(WIDTH_B);
    localparam int WMAX = (WIDTH_A > WIDTH_B) ? WIDTH_A : WIDTH_B;
    localparam logic [BW-1:0] WIN_LOW = BW'(WMAX - 1);

    generate
        if (!is_legal_width(WIDTH_A) || !is_legal_width(WIDTH_B)) begin : g_bad_width
            $error("bram_tdp_mixed_width: port widths must be 1,2,4,8,16 or 32");
        end
        if (!is_pow2(MEM_BITS) || (MEM_BITS < WMAX)) begin : g_bad_size
            $error("bram_tdp_mixed_width: MEM_BITS must be a power of two >= port width");
        end
        if ((RD_MODE_A > 2) || (RD_MODE_B > 2) || (RD_MODE_A < 0) || (RD_MODE_B < 0)) begin : g_bad_mode
            $error("bram_tdp_mixed_width: RD_MODE must be 0, 1 or 2");
        end
    endgenerate

    // Storage holds contents XOR INIT, so a zero power-up state equals the
    // INIT image without needing an initialiser on the array.
    bit   [MEM_BITS-1:0] mem_reg;

    logic [BW-1:0]       base_a, base_b;
    logic [WIDTH_A-1:0]  mask_a, wbits_a, old_a;
    logic [WIDTH_B-1:0]  mask_b, wbits_b, old_b;
    logic                wr_a, wr_b;
    logic [BW-1:0]       off_a, off_b;
    logic                same_window;
    logic [WMAX-1:0]     win_a, win_b;
    logic                collide;

    assign base_a = BW'(ADDR_A_i) << LW_A;
    assign base_b = BW'(ADDR_B_i) << LW_B;

    // Expand byte enables to per-bit masks; narrow words use enable bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH_A; gi++) begin : g_mask_a
            assign mask_a[gi] = BE_A_i[(WIDTH_A >= 8) ? (gi / 8) : 0];
        end
        for (gi = 0; gi < WIDTH_B; gi++) begin : g_mask_b
            assign mask_b[gi] = BE_B_i[(WIDTH_B >= 8) ? (gi / 8) : 0];
        end
    endgenerate

    // Writes are suppressed while reset is held.
    assign wr_a    = EN_A_i & WE_A_i & RESET_ni;
    assign wr_b    = EN_B_i & WE_B_i & RESET_ni;
    assign wbits_a = mask_a & {WIDTH_A{wr_a}};
    assign wbits_b = mask_b & {WIDTH_B{wr_b}};

    // Pre-edge contents: every reader sees old data, including cross-port.
    assign old_a = mem_reg[base_a +: WIDTH_A] ^ INIT[base_a +: WIDTH_A];
    assign old_b = mem_reg[base_b +: WIDTH_B] ^ INIT[base_b +: WIDTH_B];

    // Aligned power-of-two words either nest or are disjoint, so overlap is
    // resolved inside one window of the wider port's size.
    assign off_a       = base_a & WIN_LOW;
    assign off_b       = base_b & WIN_LOW;
    assign same_window = (base_a & ~WIN_LOW) == (base_b & ~WIN_LOW);
    assign win_a       = WMAX'(wbits_a) << off_a;
    assign win_b       = WMAX'(wbits_b) << off_b;
    assign collide     = same_window && (|(win_a & win_b));

    // Array update: B first, then A, so A owns any bit both ports write.
    always_ff @(posedge CLK_i) begin
        for (int i = 0; i < WIDTH_B; i++) begin
            if (wbits_b[i]) begin
                mem_reg[base_b + BW'(i)] <= WDATA_B_i[i] ^ INIT[base_b + BW'(i)];
            end
        end
        for (int i = 0; i < WIDTH_A; i++) begin
            if (wbits_a[i]) begin
                mem_reg[base_a + BW'(i)] <= WDATA_A_i[i] ^ INIT[base_a + BW'(i)];
            end
        end
        if (collide) begin
            $warning("bram_tdp_mixed_width: write collision, port A wins (A addr %0d, B addr %0d)",
                     ADDR_A_i, ADDR_B_i);
        end
    end

    bram_port_rdpath #(
        .W       (WIDTH_A),
        .RD_MODE (RD_MODE_A),
        .OUT_REG (OUT_REG_A)
    ) u_rdpath_a (
        .clk      (CLK_i),
        .rst_n    (RESET_ni),
        .en       (EN_A_i),
        .we       (WE_A_i),
        .old_data (old_a),
        .wdata    (WDATA_A_i),
        .wmask    (mask_a),
        .rdata    (RDATA_A_o)
    );

    bram_port_rdpath #(
        .W       (WIDTH_B),
        .RD_MODE (RD_MODE_B),
        .OUT_REG (OUT_REG_B)
    ) u_rdpath_b (
        .clk      (CLK_i),
        .rst_n    (RESET_ni),
        .en       (EN_B_i),
        .we       (WE_B_i),
        .old_data (old_b),
        .wdata    (WDATA_B_i),
        .wmask    (mask_b),
        .rdata    (RDATA_B_o)
    );

endmodule

// File: tb/tb_bram_tdp_mixed_width.sv
// Bench for bram_tdp_mixed_width: two instances (32/8 and 16/16 aspect
// ratios) checked every cycle against a bit-array model, plus directed
// literal expectations.
module tb_bram_tdp_mixed_width;

    localparam int MEMB = 32768;
    // Per-instance configuration: index 0 = 32/8, index 1 = 16/16.
    localparam int WA [2] = '{32, 16};
    localparam int WB [2] = '{8, 16};
    localparam int MA [2] = '{0, 2};
    localparam int MB [2] = '{1, 0};
    localparam int OA [2] = '{0, 1};
    localparam int OB [2] = '{0, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        en_a [2];
    logic        we_a [2];
    logic        en_b [2];
    logic        we_b [2];
    logic [3:0]  be_a [2];
    logic [3:0]  be_b [2];
    logic [11:0] addr_a [2];
    logic [11:0] addr_b [2];
    logic [31:0] wd_a [2];
    logic [31:0] wd_b [2];

    logic [31:0] rd_a0;
    logic [7:0]  rd_b0;
    logic [15:0] rd_a1;
    logic [15:0] rd_b1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bram_tdp_mixed_width #(
        .WIDTH_A(32), .WIDTH_B(8), .MEM_BITS(MEMB),
        .RD_MODE_A(0), .RD_MODE_B(1), .OUT_REG_A(0), .OUT_REG_B(0),
        .INIT('0)
    ) dut0 (
        .CLK_i(clk), .RESET_ni(rst_n),
        .EN_A_i(en_a[0]), .WE_A_i(we_a[0]), .BE_A_i(be_a[0]),
        .ADDR_A_i(addr_a[0][9:0]), .WDATA_A_i(wd_a[0]), .RDATA_A_o(rd_a0),
        .EN_B_i(en_b[0]), .WE_B_i(we_b[0]), .BE_B_i(be_b[0][0:0]),
        .ADDR_B_i(addr_b[0]), .WDATA_B_i(wd_b[0][7:0]), .RDATA_B_o(rd_b0)
    );

    bram_tdp_mixed_width #(
        .WIDTH_A(16), .WIDTH_B(16), .MEM_BITS(MEMB),
        .RD_MODE_A(2), .RD_MODE_B(0), .OUT_REG_A(1), .OUT_REG_B(0),
        .INIT('0)
    ) dut1 (
        .CLK_i(clk), .RESET_ni(rst_n),
        .EN_A_i(en_a[1]), .WE_A_i(we_a[1]), .BE_A_i(be_a[1][1:0]),
        .ADDR_A_i(addr_a[1][10:0]), .WDATA_A_i(wd_a[1][15:0]), .RDATA_A_o(rd_a1),
        .EN_B_i(en_b[1]), .WE_B_i(we_b[1]), .BE_B_i(be_b[1][1:0]),
        .ADDR_B_i(addr_b[1][10:0]), .WDATA_B_i(wd_b[1][15:0]), .RDATA_B_o(rd_b1)
    );

    // ---------------- behavioural model ----------------
    bit        mm   [2][MEMB];
    bit [31:0] st1a [2];
    bit [31:0] outa [2];
    bit [31:0] st1b [2];
    bit [31:0] outb [2];

    function automatic bit [31:0] mrd(input int d, input int w, input int addr);
        bit [31:0] r = '0;
        for (int i = 0; i < w; i++) r[i] = mm[d][addr * w + i];
        return r;
    endfunction

    function automatic bit [31:0] mmerge(input int w, input bit [31:0] old,
                                         input logic [31:0] wd, input logic [3:0] be);
        bit [31:0] r = '0;
        for (int i = 0; i < w; i++) r[i] = be[(w >= 8) ? i / 8 : 0] ? wd[i] : old[i];
        return r;
    endfunction

    task automatic mwr(input int d, input int w, input int addr,
                       input logic [31:0] wd, input logic [3:0] be);
        for (int i = 0; i < w; i++)
            if (be[(w >= 8) ? i / 8 : 0]) mm[d][addr * w + i] = wd[i];
    endtask

    function automatic bit [31:0] mnext(input int mode, input logic en, input logic we,
                                        input bit [31:0] old, input bit [31:0] nw,
                                        input bit [31:0] prev);
        if (!en) return prev;
        if (!we) return old;
        if (mode == 0) return old;
        if (mode == 1) return nw;
        return prev;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                st1a[d] = '0; outa[d] = '0; st1b[d] = '0; outb[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit [31:0] oa, ob, na, nb;
                oa = mrd(d, WA[d], int'(addr_a[d]));
                ob = mrd(d, WB[d], int'(addr_b[d]));
                na = mmerge(WA[d], oa, wd_a[d], be_a[d]);
                nb = mmerge(WB[d], ob, wd_b[d], be_b[d]);
                outa[d] = st1a[d];
                outb[d] = st1b[d];
                st1a[d] = mnext(MA[d], en_a[d], we_a[d], oa, na, st1a[d]);
                st1b[d] = mnext(MB[d], en_b[d], we_b[d], ob, nb, st1b[d]);
                if (en_b[d] && we_b[d]) mwr(d, WB[d], int'(addr_b[d]), wd_b[d], be_b[d]);
                if (en_a[d] && we_a[d]) mwr(d, WA[d], int'(addr_a[d]), wd_a[d], be_a[d]);
            end
        end
    end

    function automatic logic [31:0] exp_a(input int d);
        if (!rst_n) return '0;
        return (OA[d] != 0) ? outa[d] : st1a[d];
    endfunction

    function automatic logic [31:0] exp_b(input int d);
        if (!rst_n) return '0;
        return (OB[d] != 0) ? outb[d] : st1b[d];
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        $display("txn %-16s got %h want %h", name, act, exp);
        check(name, act, exp);
    endtask

    // Every cycle, all four read ports against the model.
    always @(negedge clk) begin
        check("cyc_a0", rd_a0, exp_a(0));
        check("cyc_b0", {24'h0, rd_b0}, exp_b(0));
        check("cyc_a1", {16'h0, rd_a1}, exp_a(1));
        check("cyc_b1", {16'h0, rd_b1}, exp_b(1));
    end

    // ---------------- stimulus ----------------
    task automatic set_a(input int d, input logic en, input logic we, input logic [3:0] be,
                         input int addr, input logic [31:0] wd);
        en_a[d] = en; we_a[d] = we; be_a[d] = be; addr_a[d] = 12'(addr); wd_a[d] = wd;
    endtask

    task automatic set_b(input int d, input logic en, input logic we, input logic [3:0] be,
                         input int addr, input logic [31:0] wd);
        en_b[d] = en; we_b[d] = we; be_b[d] = be; addr_b[d] = 12'(addr); wd_b[d] = wd;
    endtask

    task automatic idle();
        for (int d = 0; d < 2; d++) begin
            set_a(d, 1'b0, 1'b0, 4'h0, 0, 32'h0);
            set_b(d, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] bytes [4];
        bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        lit("rst_a0", rd_a0, 32'h0);
        lit("rst_b0", {24'h0, rd_b0}, 32'h0);
        lit("rst_a1", {16'h0, rd_a1}, 32'h0);
        rst_n = 1'b1;

        // Mixed-width mapping: 32-bit word 1 == bytes 4..7.
        set_a(0, 1, 1, 4'hF, 1, 32'hDDCCBBAA); step();
        for (int k = 0; k < 4; k++) begin
            idle(); set_b(0, 1, 0, 4'h0, 4 + k, 32'h0); step();
            lit($sformatf("map_b_byte%0d", 4 + k), {24'h0, rd_b0}, {24'h0, bytes[k]});
        end

        // Byte enables.
        idle(); set_a(0, 1, 1, 4'hF, 0, 32'h11223344); step();
        idle(); set_a(0, 1, 1, 4'b0101, 0, 32'hFFFFFFFF); step();
        idle(); set_a(0, 1, 0, 4'h0, 0, 32'h0); step();
        lit("be_partial", rd_a0, 32'h11FF33FF);

        // READ_FIRST on port A of dut0.
        idle(); set_a(0, 1, 1, 4'hF, 3, 32'h5); step();
        idle(); set_a(0, 1, 1, 4'hF, 3, 32'h9); step();
        lit("rf_old", rd_a0, 32'h5);
        idle(); set_a(0, 1, 0, 4'h0, 3, 32'h0); step();
        lit("rf_after", rd_a0, 32'h9);

        // WRITE_FIRST on port B of dut0, with A reading the same word.
        idle(); set_b(0, 1, 1, 4'h1, 3, 32'h5); step();
        idle(); set_b(0, 1, 1, 4'h1, 3, 32'h9); set_a(0, 1, 0, 4'h0, 0, 32'h0); step();
        lit("wf_new", {24'h0, rd_b0}, 32'h9);
        lit("xport_old", rd_a0, 32'h05FF33FF);
        idle(); set_a(0, 1, 0, 4'h0, 0, 32'h0); step();
        lit("xport_after", rd_a0, 32'h09FF33FF);

        // NO_CHANGE on port A of dut1 (output register adds one cycle).
        idle(); set_a(1, 1, 1, 4'h3, 0, 32'h1234); step();
        idle(); set_a(1, 1, 1, 4'h3, 3, 32'h5); step();
        idle(); set_a(1, 1, 1, 4'h3, 5, 32'h7); step();
        idle(); set_a(1, 1, 0, 4'h0, 5, 32'h0); step();
        idle(); set_a(1, 1, 1, 4'h3, 3, 32'h9); step();
        idle(); step();
        lit("nc_hold", {16'h0, rd_a1}, 32'h7);
        idle(); set_a(1, 1, 0, 4'h0, 3, 32'h0); step();
        idle(); step();
        lit("nc_after", {16'h0, rd_a1}, 32'h9);

        // Output register: one-cycle enable pulse, data two edges later.
        idle(); set_a(1, 1, 0, 4'h0, 0, 32'h0); step();
        lit("oreg_edge1", {16'h0, rd_a1}, 32'h9);
        idle(); step();
        lit("oreg_edge2", {16'h0, rd_a1}, 32'h1234);
        idle(); step();
        lit("oreg_persist", {16'h0, rd_a1}, 32'h1234);

        // Write collision at address 2: A wins, B reads old.
        idle(); set_b(1, 1, 1, 4'h3, 2, 32'h0F0F); step();
        idle(); set_a(1, 1, 1, 4'h3, 2, 32'hAAAA); set_b(1, 1, 1, 4'h3, 2, 32'h5555); step();
        lit("coll_b_old", {16'h0, rd_b1}, 32'h0F0F);
        idle(); set_a(1, 1, 0, 4'h0, 2, 32'h0); set_b(1, 1, 0, 4'h0, 2, 32'h0); step();
        lit("coll_b_read", {16'h0, rd_b1}, 32'hAAAA);
        idle(); step();
        lit("coll_a_read", {16'h0, rd_a1}, 32'hAAAA);

        // Asynchronous reset mid-operation.
        idle(); set_a(1, 1, 0, 4'h0, 0, 32'h0); step();
        idle(); step();
        lit("pre_reset", {16'h0, rd_a1}, 32'h1234);
        #2 rst_n = 1'b0;
        #1 lit("async_clr_a1", {16'h0, rd_a1}, 32'h0);
        lit("async_clr_a0", rd_a0, 32'h0);
        idle(); set_a(1, 1, 1, 4'h3, 0, 32'hBEEF); step();
        step();
        idle(); rst_n = 1'b1;
        set_a(1, 1, 0, 4'h0, 0, 32'h0); step();
        idle(); step();
        lit("post_reset", {16'h0, rd_a1}, 32'h1234);

        idle(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
